fifo_rd_upsizer: RTL and testbench



---
 rtl/fifo_rd_upsizer_pkg.sv | 11 +
 rtl/fifo_rd_upsizer_if.sv | 29 ++
 rtl/stream_out_reg.sv | 31 +++
 rtl/fifo_rd_upsizer.sv | 73 +++++++
 tb/tb_fifo_rd_upsizer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_upsizer_pkg.sv
// Shared defaults and helpers for the FIFO read-side upsizer.
package fifo_rd_upsizer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_RATIO = 4;

  function automatic int cnt_bits(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/fifo_rd_upsizer_if.sv
// Narrow-in / wide-out stream bundle around the upsizer.
interface fifo_rd_upsizer_if
  import fifo_rd_upsizer_pkg::*;
#(
  parameter int P_WIDTH = DEF_WIDTH,
  parameter int P_RATIO = DEF_RATIO
);

  logic [P_WIDTH-1:0]         in_data;
  logic                       in_vld;
  logic                       in_rdy;
  logic                       in_last;
  logic [P_WIDTH*P_RATIO-1:0] out_data;
  logic [P_RATIO-1:0]         out_keep;
  logic                       out_last;
  logic                       out_vld;
  logic                       out_rdy;

  modport slave (
    input  in_data, in_vld, in_last, out_rdy,
    output in_rdy, out_data, out_keep, out_last, out_vld
  );

  modport master (
    output in_data, in_vld, in_last, out_rdy,
    input  in_rdy, out_data, out_keep, out_last, out_vld
  );

endinterface

// File: rtl/stream_out_reg.sv
// Single-entry stream output register: load, hold under
// backpressure, drop valid after transfer.
module stream_out_reg #(
  parameter int P_DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [P_DW-1:0] load_data,
  output logic [P_DW-1:0] data,
  output logic            vld,
  input  logic            rdy,
  output logic            free
);

  // free may be used upstream to qualify load
  assign free = ~vld | rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      data <= load_data;
    end else if (rdy) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_upsizer.sv
// Packs P_RATIO narrow FIFO words into one wide word,
// with early close on in_last and a per-lane keep mask.
module fifo_rd_upsizer
  import fifo_rd_upsizer_pkg::*;
#(
  parameter int P_WIDTH = DEF_WIDTH,
  parameter int P_RATIO = DEF_RATIO
) (
  input logic              clk,
  input logic              rst_n,
  fifo_rd_upsizer_if.slave bus
);

  localparam int CNT_BITS = $clog2(P_RATIO);
  localparam int OUT_W    = P_WIDTH * P_RATIO;
  localparam int REG_W    = OUT_W + P_RATIO + 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX =
    CNT_BITS'(P_RATIO - 1);

  logic [P_RATIO-1:0][P_WIDTH-1:0] acc;
  logic [P_RATIO-1:0][P_WIDTH-1:0] m_data;
  logic [P_RATIO-1:0]              acc_keep;
  logic [P_RATIO-1:0]              m_keep;
  logic [CNT_BITS-1:0]             cnt;
  logic [REG_W-1:0]                reg_q;
  logic                            accept;
  logic                            close;
  logic                            free;

  assign accept = bus.in_vld & free;
  assign close  = accept & ((cnt == CNT_MAX) | bus.in_last);

  // acc lanes past cnt are always zero, so merge leaves them zero
  always_comb begin
    m_data      = acc;
    m_keep      = acc_keep;
    m_data[cnt] = bus.in_data;
    m_keep[cnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      acc_keep <= '0;
    end else if (close) begin
      cnt      <= '0;
      acc      <= '0;
      acc_keep <= '0;
    end else if (accept) begin
      cnt      <= cnt + 1'b1;
      acc      <= m_data;
      acc_keep <= m_keep;
    end
  end

  stream_out_reg #(
    .P_DW(REG_W)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (close),
    .load_data ({bus.in_last, m_keep, m_data}),
    .data      (reg_q),
    .vld       (bus.out_vld),
    .rdy       (bus.out_rdy),
    .free      (free)
  );

  assign bus.in_rdy = free;
  assign {bus.out_last, bus.out_keep, bus.out_data} = reg_q;

endmodule

// File: tb/tb_fifo_rd_upsizer.sv
// Bench for fifo_rd_upsizer: group table plus scoreboard
// and hand-written reset/backpressure/streaming sequences.
module tb_fifo_rd_upsizer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_upsizer_if #(.P_WIDTH(8), .P_RATIO(4)) bus ();

  fifo_rd_upsizer #(
    .P_WIDTH(8),
    .P_RATIO(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  typedef struct {
    logic [3:0][7:0] w;
    int              n;
    logic            last;
    logic [31:0]     exp_data;
    logic [3:0]      exp_keep;
  } vec_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int vld_cycles = 0;
  int out_cnt = 0;
  int acc_cnt = 0;
  int rdy_drops = 0;
  bit watch_rdy = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k,
                      input logic l);
    exp_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    sb.push_back(e);
  endtask

  // Output monitor: a transfer happens at the next posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_vld) vld_cycles++;
      if (bus.in_vld && bus.in_rdy) acc_cnt++;
      if (watch_rdy && !bus.in_rdy) rdy_drops++;
      if (bus.out_vld && bus.out_rdy) begin
        out_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_out", {32'b0, bus.out_data}, 64'hdead);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", {32'b0, bus.out_data}, {32'b0, e.data});
          chk("out_keep", {60'b0, bus.out_keep}, {60'b0, e.keep});
          chk("out_last", {63'b0, bus.out_last}, {63'b0, e.last});
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    bus.in_vld  = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    @(negedge clk);
    while (!bus.in_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_rdy stuck low, word %0h", d);
    end
    @(posedge clk);
    #1;
    bus.in_vld  = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{32'h44332211, 4, 1'b0, 32'h44332211, 4'b1111};
    tbl[1] = '{32'h0000BBAA, 2, 1'b1, 32'h0000BBAA, 4'b0011};
    tbl[2] = '{32'h000000C1, 1, 1'b1, 32'h000000C1, 4'b0001};
    tbl[3] = '{32'hD4D3D2D1, 4, 1'b1, 32'hD4D3D2D1, 4'b1111};
    tbl[4] = '{32'h00E3E2E1, 3, 1'b1, 32'h00E3E2E1, 4'b0111};

    bus.in_vld  = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_rdy = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_vld", {63'b0, bus.out_vld}, 64'd0);
    chk("rst_out_data", {32'b0, bus.out_data}, 64'd0);
    chk("rst_out_keep", {60'b0, bus.out_keep}, 64'd0);
    chk("rst_out_last", {63'b0, bus.out_last}, 64'd0);
    chk("rst_in_rdy", {63'b0, bus.in_rdy}, 64'd1);
    @(posedge clk);
    #1;

    // Table-driven groups, one output each
    for (int i = 0; i < 5; i++) begin
      vld_cycles = 0;
      push(tbl[i].exp_data, tbl[i].exp_keep, tbl[i].last);
      for (int j = 0; j < tbl[i].n; j++)
        send(tbl[i].w[j], tbl[i].last && (j == tbl[i].n - 1));
      idle(3);
      chk("vld_one_cycle", 64'(vld_cycles), 64'd1);
    end
    chk("sb_empty_tbl", 64'(sb.size()), 64'd0);

    // Backpressure
    bus.out_rdy = 1'b0;
    acc_cnt = 0;
    push(32'h04030201, 4'b1111, 1'b0);
    push(32'h08070605, 4'b1111, 1'b0);
    fork
      for (int k = 1; k <= 8; k++) send(8'(k), 1'b0);
    join_none
    repeat (10) @(negedge clk);
    chk("bp_out_vld", {63'b0, bus.out_vld}, 64'd1);
    chk("bp_in_rdy", {63'b0, bus.in_rdy}, 64'd0);
    chk("bp_hold", {32'b0, bus.out_data}, 64'h04030201);
    chk("bp_accepts", 64'(acc_cnt), 64'd4);
    @(posedge clk);
    #1 bus.out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", {63'b0, bus.in_rdy}, 64'd1);
    wait fork;
    idle(3);
    chk("sb_empty_bp", 64'(sb.size()), 64'd0);

    // Back-to-back closes with out_rdy=1
    out_cnt = 0;
    rdy_drops = 0;
    watch_rdy = 1;
    for (int g = 0; g < 4; g++)
      push({8'(4*g+3), 8'(4*g+2), 8'(4*g+1), 8'(4*g)},
           4'b1111, 1'b0);
    for (int k = 0; k < 16; k++) send(8'(k), 1'b0);
    watch_rdy = 0;
    idle(3);
    chk("b2b_outputs", 64'(out_cnt), 64'd4);
    chk("b2b_rdy_drops", 64'(rdy_drops), 64'd0);
    chk("sb_empty_b2b", 64'(sb.size()), 64'd0);

    // Reset mid-group discards the partial 0x55/0x66 group
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    out_cnt = 0;
    push(32'h04030201, 4'b1111, 1'b0);
    for (int k = 1; k <= 4; k++) send(8'(k), 1'b0);
    idle(4);
    chk("mid_rst_outputs", 64'(out_cnt), 64'd1);
    chk("sb_empty_rst", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
